ladybird_fetch_buffer: RTL and testbench

Sequential instruction prefetch buffer between the core's instruction port and the instruction memory bus. It streams words from a fetch pointer into a DEPTH-entry FIFO ahead of the core. It grants core fetches whose address matches the FIFO head. On a mismatch, such as a JAL target, it flushes, discards in-flight responses and restarts streaming at the requested address.

---
 rtl/ladybird_fetch_buffer.sv | 196 +++++++++++++++++++
 tb/tb_ladybird_fetch_buffer.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_fetch_buffer.sv
// ladybird_fetch_buffer: sequential instruction prefetch buffer between the
// core instruction port and the instruction memory bus.
// Build option: LADYBIRD_FETCH_PREFETCH_EN selects the streaming prefetcher;
// without it the block is a thin pass-through with a registered response.
module ladybird_fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            core_req,
    input  logic [XLEN-1:0] core_addr,
    output logic            core_gnt,
    output logic            core_data_gnt,
    output logic [XLEN-1:0] core_data,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_data_gnt,
    input  logic [XLEN-1:0] mem_data
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ladybird_fetch_buffer: DEPTH must be a power of two and at least 2");
        end
    endgenerate

`ifdef LADYBIRD_FETCH_PREFETCH_EN

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
    localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] fetch_ptr, expected_addr;
    logic [CW-1:0]   fifo_count, live_cnt, discard_cnt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] fifo_addr [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];

    // A request that was raised but not yet accepted is frozen here; if a
    // flush overtakes it, it is marked stale so its eventual word is dropped.
    logic            hold_q, hold_stale_q;
    logic [XLEN-1:0] hold_addr_q;

    logic          head_match, miss, hit, can_issue, push;
    logic          gnt_live, gnt_stale, resp_keep, resp_drop;
    logic [CW-1:0] live_after, discard_after;

    // Classify the core request, drive the bus request and settle this cycle's counter deltas.
    always_comb begin
        state_d       = state;
        head_match    = 1'b0;
        miss          = 1'b0;
        hit           = 1'b0;
        can_issue     = 1'b0;
        core_gnt      = 1'b0;
        mem_req       = 1'b0;
        mem_addr      = '0;
        gnt_live      = 1'b0;
        gnt_stale     = 1'b0;
        resp_keep     = 1'b0;
        resp_drop     = 1'b0;
        push          = 1'b0;
        live_after    = live_cnt;
        discard_after = discard_cnt;

        head_match = (fifo_count != '0) && (fifo_addr[rd_ptr] == core_addr);
        if (core_req) begin
            if (state == IDLE) begin
                miss = 1'b1;
            end else if (head_match) begin
                hit = 1'b1;
            end else if (!((fifo_count == '0) && (core_addr == expected_addr))) begin
                miss = 1'b1;
            end
        end
        if (miss) begin
            state_d = STREAM;
        end
        core_gnt = hit;

        can_issue = (state == STREAM) && !miss &&
                    ((fifo_count + live_cnt + discard_cnt) < DEPTH_C);
        mem_req   = hold_q || can_issue;
        if (hold_q) begin
            mem_addr = hold_addr_q;
        end else if (can_issue) begin
            mem_addr = fetch_ptr;
        end

        gnt_stale = mem_req && mem_gnt && hold_q && hold_stale_q;
        gnt_live  = mem_req && mem_gnt && !(hold_q && hold_stale_q);
        resp_drop = mem_data_gnt && (discard_cnt != '0);
        resp_keep = mem_data_gnt && (discard_cnt == '0) && (live_cnt != '0);
        push      = resp_keep && !miss;

        live_after    = live_cnt + CW'(gnt_live) - CW'(resp_keep);
        discard_after = discard_cnt + CW'(gnt_stale) - CW'(resp_drop);
    end

    // State register: leaves IDLE on the first request and then streams until reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Pointers, occupancy, in-flight bookkeeping and the core response register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fetch_ptr     <= '0;
            expected_addr <= '0;
            fifo_count    <= '0;
            live_cnt      <= '0;
            discard_cnt   <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            hold_q        <= 1'b0;
            hold_stale_q  <= 1'b0;
            hold_addr_q   <= '0;
            core_data_gnt <= 1'b0;
            core_data     <= '0;
        end else begin
            core_data_gnt <= hit;
            if (hit) begin
                core_data <= fifo_data[rd_ptr];
            end

            hold_q       <= mem_req && !mem_gnt;
            hold_addr_q  <= mem_addr;
            hold_stale_q <= mem_req && !mem_gnt && (miss || (hold_q && hold_stale_q));

            if (miss) begin
                fetch_ptr     <= core_addr;
                expected_addr <= core_addr;
                live_cnt      <= '0;
                discard_cnt   <= live_after + discard_after;
                fifo_count    <= '0;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
            end else begin
                if (gnt_live) begin
                    fetch_ptr <= fetch_ptr + WORD_STEP;
                end
                live_cnt    <= live_after;
                discard_cnt <= discard_after;
                if (push) begin
                    wr_ptr        <= wr_ptr + PW'(1);
                    expected_addr <= expected_addr + WORD_STEP;
                end
                if (hit) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                fifo_count <= fifo_count + CW'(push) - CW'(hit);
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= expected_addr;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

`else

    // Pass-through: the core talks straight to memory, held quiet while in reset.
    always_comb begin
        mem_req  = core_req && !arst;
        mem_addr = arst ? '0 : core_addr;
        core_gnt = mem_gnt && !arst;
    end

    // The read response is retimed by one register stage toward the core.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            core_data_gnt <= 1'b0;
            core_data     <= '0;
        end else begin
            core_data_gnt <= mem_data_gnt;
            core_data     <= mem_data;
        end
    end

`endif

endmodule

// File: tb/tb_ladybird_fetch_buffer.sv
// Testbench for ladybird_fetch_buffer. Exercises the prefetch build when
// LADYBIRD_FETCH_PREFETCH_EN is defined, otherwise the pass-through build.
module tb_ladybird_fetch_buffer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        core_req = 1'b0;
    logic [31:0] core_addr = '0;
    logic        core_gnt;
    logic        core_data_gnt;
    logic [31:0] core_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_data_gnt = 1'b0;
    logic [31:0] mem_data = '0;

    int vectors = 0;
    int fails   = 0;

    ladybird_fetch_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .clk           (clk),
        .arst          (arst),
        .core_req      (core_req),
        .core_addr     (core_addr),
        .core_gnt      (core_gnt),
        .core_data_gnt (core_data_gnt),
        .core_data     (core_data),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_gnt       (mem_gnt),
        .mem_data_gnt  (mem_data_gnt),
        .mem_data      (mem_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    // Memory model: grants unless stalled at stall_addr, answers in order after lat cycles.
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] issue_log[$];
    int          cyc = 0;
    int          lat = 1;
    int          outstanding = 0;
    int          max_out = 0;
    logic        stall_active = 1'b0;
    logic [31:0] stall_addr = '0;

    assign mem_gnt = mem_req && !(stall_active && (mem_addr == stall_addr));

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (arst) begin
            q_addr.delete();
            q_due.delete();
            outstanding = 0;
        end else if (mem_req && mem_gnt) begin
            q_addr.push_back(mem_addr);
            q_due.push_back(cyc + lat - 1);
            issue_log.push_back(mem_addr);
            outstanding = outstanding + 1;
            if (outstanding > max_out) max_out = outstanding;
        end
        #1;
        mem_data_gnt = 1'b0;
        mem_data     = '0;
        if (!arst && q_addr.size() > 0 && q_due[0] <= cyc) begin
            mem_data_gnt = 1'b1;
            mem_data     = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
            outstanding = outstanding - 1;
        end
    end

    task automatic do_reset();
        core_req     = 1'b0;
        core_addr    = '0;
        stall_active = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        issue_log.delete();
        max_out = 0;
    endtask

    // Holds a request until granted (bounded), then checks the word dly cycles later.
    task automatic fetch(input logic [31:0] a, input int dly, output int waited);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        core_req  = 1'b1;
        core_addr = a;
        @(negedge clk);
        while (core_gnt !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        waited = n;
        vectors++;
        if (core_gnt !== 1'b1) begin
            fails++;
            $display("[TB] FAIL grant_timeout addr=%h core_gnt=%b want 1", a, core_gnt);
            core_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        core_req = 1'b0;
        repeat (dly - 1) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (core_data_gnt !== 1'b1 || core_data !== mem_word(a)) begin
            fails++;
            $display("[TB] FAIL fetch_data addr=%h got gnt=%b data=%h want gnt=1 data=%h",
                     a, core_data_gnt, core_data, mem_word(a));
        end
    endtask

    task automatic test_reset();
        core_req  = 1'b1;
        core_addr = 32'h0000_1234;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (core_gnt !== 1'b0) begin fails++; $display("[TB] FAIL reset_core_gnt got %b want 0", core_gnt); end
        vectors++;
        if (core_data_gnt !== 1'b0) begin fails++; $display("[TB] FAIL reset_core_data_gnt got %b want 0", core_data_gnt); end
        vectors++;
        if (core_data !== 32'h0) begin fails++; $display("[TB] FAIL reset_core_data got %h want 0", core_data); end
        vectors++;
        if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_req got %b want 0", mem_req); end
        vectors++;
        if (mem_addr !== 32'h0) begin fails++; $display("[TB] FAIL reset_mem_addr got %h want 0", mem_addr); end
        core_req = 1'b0;
        @(negedge clk);
        arst = 1'b0;
    endtask

`ifdef LADYBIRD_FETCH_PREFETCH_EN

    task automatic test_cold_start();
        int w;
        logic [31:0] exp_log [4];
        exp_log = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        lat = 1;
        fetch(32'h0, 1, w);
        vectors++;
        if (w !== 3) begin fails++; $display("[TB] FAIL cold_latency got %0d want 3", w); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (issue_log.size() <= i || issue_log[i] !== exp_log[i]) begin
                fails++;
                $display("[TB] FAIL cold_issue_%0d got %h want %h", i,
                         (issue_log.size() > i) ? issue_log[i] : 32'hxxxx_xxxx, exp_log[i]);
            end
        end
    endtask

    task automatic test_sequential();
        int w;
        for (int a = 4; a <= 32'h3C; a += 4) begin
            repeat (3) @(posedge clk);
            fetch(32'(a), 1, w);
            vectors++;
            if (w !== 0) begin fails++; $display("[TB] FAIL seq_hit addr=%h waited %0d want 0", a, w); end
        end
        vectors++;
        if (max_out > 4) begin fails++; $display("[TB] FAIL seq_outstanding got %0d want <=4", max_out); end
    endtask

    task automatic test_depth_limit();
        int w;
        do_reset();
        lat = 8;
        fetch(32'h0, 1, w);
        vectors++;
        if (w !== 10) begin fails++; $display("[TB] FAIL depth_latency got %0d want 10", w); end
        vectors++;
        if (max_out !== 4) begin fails++; $display("[TB] FAIL depth_outstanding got %0d want 4", max_out); end
    endtask

    task automatic test_jump();
        int w;
        do_reset();
        lat = 3;
        fetch(32'h0, 1, w);
        fetch(32'h4, 1, w);
        fetch(32'h8, 1, w);
        fetch(32'h100, 1, w);
        fetch(32'h104, 1, w);
        fetch(32'h108, 1, w);
    endtask

    task automatic test_stall_flush();
        int w;
        int idx;
        do_reset();
        lat = 1;
        stall_addr   = 32'h14;
        stall_active = 1'b1;
        fetch(32'h10, 1, w);
        @(posedge clk);
        #1;
        core_req  = 1'b1;
        core_addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin
                fails++;
                $display("[TB] FAIL stall_hold_%0d got req=%b addr=%h want req=1 addr=00000014", i, mem_req, mem_addr);
            end
        end
        stall_active = 1'b0;
        fetch(32'h200, 1, w);
        fetch(32'h204, 1, w);
        idx = -1;
        for (int i = 0; i < issue_log.size(); i++) if (issue_log[i] == 32'h14) idx = i;
        vectors++;
        if (idx < 0 || idx + 1 >= issue_log.size() || issue_log[idx+1] !== 32'h200) begin
            fails++;
            $display("[TB] FAIL stall_restart index=%0d log_size=%0d want read after 00000014 at 00000200", idx, issue_log.size());
        end
    endtask

    task automatic test_wrap();
        int w;
        logic [31:0] exp_log [3];
        exp_log = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        do_reset();
        lat = 1;
        fetch(32'hFFFF_FFF8, 1, w);
        fetch(32'hFFFF_FFFC, 1, w);
        fetch(32'h0, 1, w);
        vectors++;
        if (w !== 0) begin fails++; $display("[TB] FAIL wrap_hit waited %0d want 0", w); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (issue_log.size() <= i || issue_log[i] !== exp_log[i]) begin
                fails++;
                $display("[TB] FAIL wrap_issue_%0d got %h want %h", i,
                         (issue_log.size() > i) ? issue_log[i] : 32'hxxxx_xxxx, exp_log[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int w;
        int n;
        do_reset();
        lat = 1;
        fetch(32'h40, 1, w);
        lat = 5;
        @(posedge clk);
        #1;
        core_req  = 1'b1;
        core_addr = 32'h80;
        n = 0;
        while (outstanding < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (outstanding < 3) begin fails++; $display("[TB] FAIL arst_setup outstanding %0d want >=3", outstanding); end
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        vectors++;
        if (core_gnt !== 1'b0 || core_data_gnt !== 1'b0 || core_data !== 32'h0 ||
            mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            fails++;
            $display("[TB] FAIL arst_outputs got gnt=%b dgnt=%b data=%h req=%b addr=%h want all 0",
                     core_gnt, core_data_gnt, core_data, mem_req, mem_addr);
        end
        core_req = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        lat  = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (mem_req !== 1'b0) begin fails++; $display("[TB] FAIL arst_idle_%0d mem_req got %b want 0", i, mem_req); end
        end
        fetch(32'h40, 1, w);
        vectors++;
        if (w !== 3) begin fails++; $display("[TB] FAIL arst_cold_latency got %0d want 3", w); end
    endtask

`else

    task automatic test_passthrough();
        int w;
        lat = 1;
        fetch(32'h300, 2, w);
        vectors++;
        if (w !== 0) begin fails++; $display("[TB] FAIL pt_gnt_300 waited %0d want 0", w); end
        fetch(32'h1000, 2, w);
        vectors++;
        if (w !== 0) begin fails++; $display("[TB] FAIL pt_gnt_1000 waited %0d want 0", w); end
        lat = 3;
        fetch(32'h2004, 4, w);
        vectors++;
        if (w !== 0) begin fails++; $display("[TB] FAIL pt_gnt_2004 waited %0d want 0", w); end
        @(negedge clk);
        vectors++;
        if (core_data_gnt !== 1'b0) begin fails++; $display("[TB] FAIL pt_pulse core_data_gnt got %b want 0", core_data_gnt); end
    endtask

    task automatic test_stall();
        lat = 1;
        stall_addr   = 32'h500;
        stall_active = 1'b1;
        @(posedge clk);
        #1;
        core_req  = 1'b1;
        core_addr = 32'h500;
        @(negedge clk);
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
            fails++;
            $display("[TB] FAIL pt_stall_req got req=%b addr=%h want req=1 addr=00000500", mem_req, mem_addr);
        end
        vectors++;
        if (core_gnt !== 1'b0) begin fails++; $display("[TB] FAIL pt_stall_gnt got %b want 0", core_gnt); end
        stall_active = 1'b0;
        #1;
        vectors++;
        if (core_gnt !== 1'b1) begin fails++; $display("[TB] FAIL pt_release_gnt got %b want 1", core_gnt); end
        @(posedge clk);
        #1;
        core_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (core_data_gnt !== 1'b1 || core_data !== mem_word(32'h500)) begin
            fails++;
            $display("[TB] FAIL pt_stall_data got gnt=%b data=%h want gnt=1 data=%h",
                     core_data_gnt, core_data, mem_word(32'h500));
        end
    endtask

    task automatic test_async_reset();
        int w;
        lat = 1;
        fetch(32'h700, 2, w);
        core_req  = 1'b1;
        core_addr = 32'h704;
        @(negedge clk);
        arst = 1'b1;
        #1;
        vectors++;
        if (core_data !== 32'h0 || core_data_gnt !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pt_arst_data got gnt=%b data=%h want 0", core_data_gnt, core_data);
        end
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || core_gnt !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pt_arst_bus got req=%b addr=%h gnt=%b want 0", mem_req, mem_addr, core_gnt);
        end
        core_req = 1'b0;
        @(negedge clk);
        arst = 1'b0;
    endtask

`endif

    initial begin
        test_reset();
`ifdef LADYBIRD_FETCH_PREFETCH_EN
        test_cold_start();
        test_sequential();
        test_depth_limit();
        test_jump();
        test_stall_flush();
        test_wrap();
        test_async_reset();
`else
        test_passthrough();
        test_stall();
        test_async_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
